// File: rtl/tape_pkg.sv
// Shared cassette timing and FSM types for the tape recorder and playback synthesizer.
package tape_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitData,
    StWaitClk
  } tape_state_e;

  // Offsets in CPU-enable ticks, measured from the last accepted clock pulse.
  localparam logic [11:0] TapeDataMin    = 12'h500;
  localparam logic [11:0] TapeDataMax    = 12'h900;
  localparam logic [11:0] TapeClkMin     = 12'hC00;
  localparam logic [11:0] TapeTimeout    = 12'hFFF;
  localparam logic [11:0] TapePeriod     = 12'hE08;
  localparam logic [11:0] TapeDataOffset = 12'h6FF;

endpackage

// File: rtl/tape_recorder_if.sv
// Tape-side inputs plus host readback/status for the tape recorder.
interface tape_recorder_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              ce;
  logic              motor;
  logic              tape_out;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [ADDR_W:0]   length;
  logic              recording;
  logic              overflow;
  logic              byte_strobe;
  logic              glitch;

  modport master (
    output ce, motor, tape_out, rd_addr,
    input  rd_data, length, recording, overflow, byte_strobe, glitch
  );

  modport slave (
    input  ce, motor, tape_out, rd_addr,
    output rd_data, length, recording, overflow, byte_strobe, glitch
  );
endinterface

// File: rtl/tape_capture_ram.sv
// Simple dual-port byte RAM: internal write port, registered host read port.
module tape_capture_ram #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  localparam int unsigned Depth = 1 << ADDR_W;

  logic [7:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-address read during a write returns the old byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tape_recorder.sv
// Cassette write-side decoder: times CPU-driven tape pulses, splits clock/data
// pulses, assembles bytes MSB first and stores them in a capture RAM.
module tape_recorder
  import tape_pkg::*;
#(
  parameter int unsigned ADDR_W   = 17,
  parameter logic [11:0] DATA_MIN = TapeDataMin,
  parameter logic [11:0] DATA_MAX = TapeDataMax,
  parameter logic [11:0] CLK_MIN  = TapeClkMin,
  parameter logic [11:0] TIMEOUT  = TapeTimeout
) (
  input logic            clock,
  input logic            reset,
  tape_recorder_if.slave bus
);

  tape_state_e     state_q, state_d;
  logic [11:0]     cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic            data_seen_q, data_seen_d;
  logic [ADDR_W:0] length_q, length_d;
  logic            overflow_q, overflow_d;
  logic            glitch_q, glitch_d;
  logic            wr_pend_q, wr_pend_d;
  logic            tape_q, motor_q;

  logic rise, motor_on, full, wr_en;
  logic bit_done, bit_val;

  assign rise     = bus.tape_out & ~tape_q;
  assign motor_on = bus.motor & ~motor_q;
  assign full     = length_q[ADDR_W];
  assign wr_en    = wr_pend_q & ~full;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    data_seen_d = data_seen_q;
    length_d    = length_q;
    overflow_d  = overflow_q;
    glitch_d    = glitch_q;
    wr_pend_d   = 1'b0;
    bit_done    = 1'b0;
    bit_val     = 1'b0;

    // Byte completed on the previous ce is committed (or dropped) this clock.
    if (wr_pend_q) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        length_d = length_q + {{ADDR_W{1'b0}}, 1'b1};
      end
    end

    if (bus.ce) begin
      if (state_q != StIdle && cnt_q != TIMEOUT) begin
        cnt_d = cnt_q + 12'd1;
      end

      if (motor_on) begin
        state_d    = StIdle;
        length_d   = '0;
        bitcnt_d   = '0;
        overflow_d = 1'b0;
        glitch_d   = 1'b0;
      end else if (!bus.motor) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              state_d     = StWaitData;
              cnt_d       = '0;
              data_seen_d = 1'b0;
            end
          end
          StWaitData: begin
            // A rise landing on the decision point is too late to be data.
            if (cnt_q == DATA_MAX) begin
              bit_done = 1'b1;
              bit_val  = data_seen_q;
              state_d  = StWaitClk;
              if (rise) begin
                glitch_d = 1'b1;
              end
            end else if (rise) begin
              if (cnt_q >= DATA_MIN) begin
                data_seen_d = 1'b1;
              end else begin
                glitch_d = 1'b1;
              end
            end
          end
          StWaitClk: begin
            if (rise) begin
              if (cnt_q >= CLK_MIN) begin
                state_d     = StWaitData;
                cnt_d       = '0;
                data_seen_d = 1'b0;
              end else begin
                glitch_d = 1'b1;
              end
            end else if (cnt_q == TIMEOUT) begin
              state_d  = StIdle;
              bitcnt_d = '0;
            end
          end
          default: state_d = StIdle;
        endcase
      end

      if (bit_done) begin
        shift_d   = {shift_q[6:0], bit_val};
        bitcnt_d  = bitcnt_q + 3'd1;
        wr_pend_d = (bitcnt_q == 3'd7);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      data_seen_q <= 1'b0;
      length_q    <= '0;
      overflow_q  <= 1'b0;
      glitch_q    <= 1'b0;
      wr_pend_q   <= 1'b0;
      tape_q      <= 1'b0;
      motor_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      data_seen_q <= data_seen_d;
      length_q    <= length_d;
      overflow_q  <= overflow_d;
      glitch_q    <= glitch_d;
      wr_pend_q   <= wr_pend_d;
      if (bus.ce) begin
        tape_q  <= bus.tape_out;
        motor_q <= bus.motor;
      end
    end
  end

  assign bus.length      = length_q;
  assign bus.recording   = motor_q & ~full;
  assign bus.overflow    = overflow_q;
  assign bus.glitch      = glitch_q;
  assign bus.byte_strobe = wr_en;

  tape_capture_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (length_q[ADDR_W-1:0]),
    .wr_data (shift_q),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_tape_recorder.sv
// Directed bench for tape_recorder; timing windows are the shared constants scaled by 1/32.
module tb_tape_recorder;
  import tape_pkg::*;

  localparam logic [11:0] DMin = TapeDataMin >> 5;  // 0x028
  localparam logic [11:0] DMax = TapeDataMax >> 5;  // 0x048
  localparam logic [11:0] CMin = TapeClkMin >> 5;   // 0x060
  localparam logic [11:0] TOut = TapeTimeout >> 5;  // 0x07F
  localparam int Period    = int'(TapePeriod >> 5);      // 0x70
  localparam int DataOff   = int'(TapeDataOffset >> 5);  // 0x37
  localparam int GlitchOff = 8;
  localparam int PulseW    = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        motor = 1'b0;
  logic        tape_out = 1'b0;
  logic [16:0] rd_addr = '0;

  int n_checks = 0;
  int n_pass = 0;
  int strobes_big = 0;
  int strobe_base;
  logic [7:0] db, ds;

  tape_recorder_if #(.ADDR_W(17)) bus_big ();
  tape_recorder_if #(.ADDR_W(2))  bus_small ();

  assign bus_big.ce         = ce;
  assign bus_big.motor      = motor;
  assign bus_big.tape_out   = tape_out;
  assign bus_big.rd_addr    = rd_addr;
  assign bus_small.ce       = ce;
  assign bus_small.motor    = motor;
  assign bus_small.tape_out = tape_out;
  assign bus_small.rd_addr  = rd_addr[1:0];

  tape_recorder #(
    .ADDR_W(17), .DATA_MIN(DMin), .DATA_MAX(DMax), .CLK_MIN(CMin), .TIMEOUT(TOut)
  ) dut_big (
    .clock (clock),
    .reset (reset),
    .bus   (bus_big)
  );

  tape_recorder #(
    .ADDR_W(2), .DATA_MIN(DMin), .DATA_MAX(DMax), .CLK_MIN(CMin), .TIMEOUT(TOut)
  ) dut_small (
    .clock (clock),
    .reset (reset),
    .bus   (bus_small)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus_big.byte_strobe) strobes_big <= strobes_big + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Each tick is one clock with ce high followed by one clock with ce low.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ce = 1'b1;
      @(negedge clock);
      ce = 1'b0;
    end
  endtask

  task automatic motor_cycle();
    motor = 1'b0;
    ticks(2);
    motor = 1'b1;
    ticks(2);
  endtask

  task automatic send_frame(input logic b, input logic g);
    tape_out = 1'b1;
    ticks(PulseW);
    tape_out = 1'b0;
    if (g) begin
      ticks(GlitchOff - PulseW);
      tape_out = 1'b1;
      ticks(PulseW);
      tape_out = 1'b0;
      ticks(DataOff - GlitchOff - PulseW);
    end else begin
      ticks(DataOff - PulseW);
    end
    if (b) begin
      tape_out = 1'b1;
      ticks(PulseW);
      tape_out = 1'b0;
      ticks(Period - DataOff - PulseW);
    end else begin
      ticks(Period - DataOff);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int glitch_frame);
    for (int i = 7; i >= 0; i--) send_frame(v[i], (i == glitch_frame));
  endtask

  task automatic rd(input logic [16:0] a, output logic [7:0] big_d, output logic [7:0] small_d);
    rd_addr = a;
    @(posedge clock);
    #1;
    big_d   = bus_big.rd_data;
    small_d = bus_small.rd_data;
  endtask

  initial begin
    #12;
    check("rst_length", 32'(bus_big.length), 0);
    check("rst_rd_data", 32'(bus_big.rd_data), 0);
    check("rst_recording", 32'(bus_big.recording), 0);
    check("rst_overflow", 32'(bus_big.overflow), 0);
    check("rst_glitch", 32'(bus_big.glitch), 0);
    check("rst_strobe", 32'(bus_big.byte_strobe), 0);
    @(negedge clock);
    reset = 1'b0;

    // Single byte A5
    motor_cycle();
    check("t1_recording", 32'(bus_big.recording), 1);
    strobe_base = strobes_big;
    send_byte(8'hA5, -1);
    check("t1_length", 32'(bus_big.length), 1);
    check("t1_strobes", 32'(strobes_big - strobe_base), 1);
    check("t1_glitch", 32'(bus_big.glitch), 0);
    rd(17'd0, db, ds);
    check("t1_ram0", 32'(db), 'hA5);

    // Back-to-back bytes
    motor_cycle();
    check("t2_length_clr", 32'(bus_big.length), 0);
    strobe_base = strobes_big;
    send_byte(8'h00, -1);
    send_byte(8'hFF, -1);
    send_byte(8'h3C, -1);
    check("t2_length", 32'(bus_big.length), 3);
    check("t2_strobes", 32'(strobes_big - strobe_base), 3);
    rd(17'd0, db, ds);
    check("t2_ram0", 32'(db), 'h00);
    rd(17'd1, db, ds);
    check("t2_ram1", 32'(db), 'hFF);
    rd(17'd2, db, ds);
    check("t2_ram2", 32'(db), 'h3C);

    // Partial byte abandoned on timeout
    motor_cycle();
    for (int i = 0; i < 5; i++) send_frame(((i % 2) == 0), 1'b0);
    ticks(256);
    check("t3_length_partial", 32'(bus_big.length), 0);
    send_byte(8'h81, -1);
    check("t3_length", 32'(bus_big.length), 1);
    rd(17'd0, db, ds);
    check("t3_ram0", 32'(db), 'h81);

    // Early rise inside a frame
    motor_cycle();
    check("t4_glitch_pre", 32'(bus_big.glitch), 0);
    send_byte(8'h55, 5);
    check("t4_glitch", 32'(bus_big.glitch), 1);
    check("t4_length", 32'(bus_big.length), 1);
    rd(17'd0, db, ds);
    check("t4_ram0", 32'(db), 'h55);

    // Overflow on the 4-byte instance
    motor_cycle();
    check("t5_glitch_clr", 32'(bus_big.glitch), 0);
    send_byte(8'h11, -1);
    send_byte(8'h22, -1);
    send_byte(8'h33, -1);
    send_byte(8'h44, -1);
    check("t5_small_ovf_pre", 32'(bus_small.overflow), 0);
    send_byte(8'h55, -1);
    check("t5_small_length", 32'(bus_small.length), 4);
    check("t5_small_overflow", 32'(bus_small.overflow), 1);
    check("t5_small_recording", 32'(bus_small.recording), 0);
    check("t5_big_length", 32'(bus_big.length), 5);
    check("t5_big_overflow", 32'(bus_big.overflow), 0);
    rd(17'd0, db, ds);
    check("t5_small_ram0", 32'(ds), 'h11);
    rd(17'd1, db, ds);
    check("t5_small_ram1", 32'(ds), 'h22);
    rd(17'd2, db, ds);
    check("t5_small_ram2", 32'(ds), 'h33);
    rd(17'd3, db, ds);
    check("t5_small_ram3", 32'(ds), 'h44);
    rd(17'd4, db, ds);
    check("t5_big_ram4", 32'(db), 'h55);
    motor_cycle();
    check("t5_small_length_clr", 32'(bus_small.length), 0);
    check("t5_small_ovf_clr", 32'(bus_small.overflow), 0);
    check("t5_small_recording_on", 32'(bus_small.recording), 1);

    // Asynchronous reset mid-byte
    send_byte(8'h99, -1);
    check("t6_length_pre", 32'(bus_big.length), 1);
    for (int i = 0; i < 4; i++) send_frame(((i % 2) == 0), 1'b0);
    rd(17'd0, db, ds);
    check("t6_ram0_pre", 32'(db), 'h99);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_length", 32'(bus_big.length), 0);
    check("t6_rst_rd_data", 32'(bus_big.rd_data), 0);
    check("t6_rst_recording", 32'(bus_big.recording), 0);
    @(negedge clock);
    reset = 1'b0;
    ticks(2);
    send_byte(8'hC3, -1);
    check("t6_length", 32'(bus_big.length), 1);
    rd(17'd0, db, ds);
    check("t6_ram0", 32'(db), 'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
